// File: rtl/pri_irq_pkg.sv
// Shared constants and FSM state encoding for the priority interrupt controller.
package pri_irq_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned ID_W   = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-input priority encoder; the highest set index wins.
module pri_enc8
    import pri_irq_pkg::*;
(
    input  logic [NUM_CH-1:0] in,
    output logic [ID_W-1:0]   idx,
    output logic              valid
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (in[i]) idx = ID_W'(i);
        end
    end

    assign valid = |in;

endmodule

// File: rtl/pri_irq_ctrl.sv
// Eight-channel rising-edge interrupt latch with fixed priority selection and
// a non-preemptive present/acknowledge handshake.
module pri_irq_ctrl
    import pri_irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic              ack,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [NUM_CH-1:0] pending
);

    state_t              state;
    logic [NUM_CH-1:0]   req_q;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   clr;
    logic [ID_W-1:0]     sel_idx;
    logic                sel_valid;

    assign rise = req & ~req_q;

    // Only the channel being presented is retired, and only while ACTIVE.
    assign clr = (state == ACTIVE && ack) ? (NUM_CH'(1) << irq_id) : '0;

    pri_enc8 u_enc (
        .in    (pending & mask),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= '0;
            pending <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
        end else begin
            req_q   <= req;
            // A new edge on the retired channel wins over the clear.
            pending <= (pending & ~clr) | rise;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        irq_id <= sel_idx;
                        irq    <= 1'b1;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (ack) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pri_irq_ctrl.sv
// Self-checking bench for pri_irq_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_pri_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       ack = 1'b0;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_prev;
    logic       m_irq;
    logic [2:0] m_id;

    pri_irq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .mask    (mask),
        .ack     (ack),
        .irq     (irq),
        .irq_id  (irq_id),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend = 8'h00;
        m_prev = 8'h00;
        m_irq  = 1'b0;
        m_id   = 3'd0;
    endtask

    // Advance the model by one clock using the inputs as driven before the edge.
    task automatic model_clock();
        logic [7:0] elig;
        logic [7:0] new_pend;
        int         top;
        new_pend = m_pend;
        if (m_irq && ack) begin
            new_pend[m_id] = 1'b0;
            m_irq = 1'b0;
        end else if (!m_irq) begin
            elig = m_pend & mask;
            top = -1;
            for (int i = 0; i < 8; i++) if (elig[i]) top = i;
            if (top >= 0) begin
                m_irq = 1'b1;
                m_id  = 3'(top);
            end
        end
        m_pend = new_pend | (req & ~m_prev);
        m_prev = req;
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a);
        req  = r;
        mask = m;
        ack  = a;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset(input logic [7:0] r);
        @(negedge clk);
        rst_n = 1'b0;
        req   = r;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(8'hFF);
        rst_n = 1'b0;
        mask  = 8'hFF;
        #1;
        n_cmp++;
        if ({irq, irq_id, pending} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_hold: irq=%0b id=%0d pend=%h want 0/0/00", irq, irq_id, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 8'hFF, 1'b0);
        n_cmp++;
        if (pending !== 8'hFF || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_edge: pend=%h irq=%0b want FF/0", pending, irq);
        end
        step(8'hFF, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd7) begin
            n_bad++;
            $display("FAIL reset_first_irq: irq=%0b id=%0d want 1/7", irq, irq_id);
        end
    endtask

    task automatic test_single();
        do_reset(8'h00);
        step(8'h01, 8'hFF, 1'b0);
        n_cmp++;
        if (pending !== 8'h01 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pend: pend=%h irq=%0b want 01/0", pending, irq);
        end
        step(8'h01, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd0) begin
            n_bad++;
            $display("FAIL single_irq: irq=%0b id=%0d want 1/0", irq, irq_id);
        end
        step(8'h01, 8'hFF, 1'b1);
        n_cmp++;
        if (pending !== 8'h00 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack: pend=%h irq=%0b want 00/0", pending, irq);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(8'h00);
        step(8'h24, 8'hFF, 1'b0);
        step(8'h24, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd5) begin
            n_bad++;
            $display("FAIL simul_first: irq=%0b id=%0d want 1/5", irq, irq_id);
        end
        step(8'h24, 8'hFF, 1'b1);
        n_cmp++;
        if (irq !== 1'b0 || pending !== 8'h04) begin
            n_bad++;
            $display("FAIL simul_gap: irq=%0b pend=%h want 0/04", irq, pending);
        end
        step(8'h24, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd2) begin
            n_bad++;
            $display("FAIL simul_second: irq=%0b id=%0d want 1/2", irq, irq_id);
        end
        step(8'h24, 8'hFF, 1'b1);
        n_cmp++;
        if (pending !== 8'h00 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_drain: pend=%h irq=%0b want 00/0", pending, irq);
        end
    endtask

    task automatic test_no_preempt();
        do_reset(8'h00);
        step(8'h04, 8'hFF, 1'b0);
        step(8'h04, 8'hFF, 1'b0);
        step(8'h84, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd2 || pending !== 8'h84) begin
            n_bad++;
            $display("FAIL preempt_hold: irq=%0b id=%0d pend=%h want 1/2/84", irq, irq_id, pending);
        end
        step(8'h84, 8'hFF, 1'b1);
        step(8'h84, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd7) begin
            n_bad++;
            $display("FAIL preempt_next: irq=%0b id=%0d want 1/7", irq, irq_id);
        end
    endtask

    task automatic test_masking();
        do_reset(8'h00);
        step(8'h10, 8'h00, 1'b0);
        step(8'h10, 8'h00, 1'b0);
        n_cmp++;
        if (pending !== 8'h10 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mask_block: pend=%h irq=%0b want 10/0", pending, irq);
        end
        step(8'h10, 8'h10, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd4) begin
            n_bad++;
            $display("FAIL mask_enable: irq=%0b id=%0d want 1/4", irq, irq_id);
        end
    endtask

    task automatic test_collision();
        do_reset(8'h00);
        step(8'h08, 8'hFF, 1'b0);
        step(8'h08, 8'hFF, 1'b0);
        step(8'h00, 8'hFF, 1'b0);
        step(8'h08, 8'hFF, 1'b1);
        n_cmp++;
        if (pending !== 8'h08 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_set_wins: pend=%h irq=%0b want 08/0", pending, irq);
        end
        step(8'h08, 8'hFF, 1'b0);
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== 3'd3) begin
            n_bad++;
            $display("FAIL collide_reassert: irq=%0b id=%0d want 1/3", irq, irq_id);
        end
        // Reset mid-ACTIVE, away from the clock edge.
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({irq, irq_id, pending} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_active: irq=%0b id=%0d pend=%h want 0/0/00", irq, irq_id, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset(8'h00);
        r = 8'h00;
        for (int c = 0; c < 600; c++) begin
            r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            step(r, (($urandom % 8) == 0) ? 8'($urandom) : ((c % 200 < 100) ? 8'hFF : 8'h5A),
                 ($urandom % 3) == 0);
            n_cmp++;
            if (irq !== m_irq || irq_id !== m_id || pending !== m_pend) begin
                n_bad++;
                $display("FAIL random_c%0d: irq=%0b id=%0d pend=%h want %0b/%0d/%h",
                         c, irq, irq_id, pending, m_irq, m_id, m_pend);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_simultaneous();
        test_no_preempt();
        test_masking();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
